alu_mesh_dispatch: RTL and testbench
====================================

// Module: alu_mesh_dispatch
// PURPOSE
//  Upstream request front-end for the 3x3 ALU tile mesh. Accepts one (a, b, mode) op per
//  valid/ready handshake, broadcasts it to all tiles, waits a settle window, then
//  gathers the per-tile result/match vectors into one response on a valid/ready output.
//  Flags ops that hit no tile, or more than one, as errors. Single op in flight.
// PARAMETERS
//  NUM_TILES      9   tiles in mesh; tile i result at tile_result[64*i+:64], match at tile_match[i]
//  SETTLE_CYCLES  1   extra clocks the mesh is driven before capture (0..15)
//  IDLE_MODE      15  mode driven to mesh when no op is in flight (must match no tile)
// PORTS
//  clk          in   1              single clock, rising edge
//  rst_n        in   1              asynchronous, active-low reset
//  req_valid    in   1              request valid
//  req_ready    out  1              dispatcher can accept a request
//  req_a        in   64             operand a
//  req_b        in   64             operand b
//  req_mode     in   4              op code (0..8 valid)
//  tile_a       out  64             operand a broadcast to all tiles (registered)
//  tile_b       out  64             operand b broadcast (registered)
//  tile_mode    out  4              mode broadcast (registered)
//  tile_result  in   64*NUM_TILES   concatenated tile result_out
//  tile_match   in   NUM_TILES      concatenated tile match
//  rsp_valid    out  1              response valid
//  rsp_ready    in   1              consumer accepts response
//  rsp_result   out  64             bitwise OR of all tile results at capture
//  rsp_mode     out  4              mode of the op being answered
//  rsp_tile     out  4              index of lowest matching tile; 4'hF if none
//  rsp_err      out  1              match count != 1
//  op_count     out  32             responses completed since reset, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE; req_ready=1; tile_a=tile_b=0; tile_mode=IDLE_MODE;
//   rsp_valid=0; rsp_result=0; rsp_mode=0; rsp_tile=4'hF; rsp_err=0; op_count=0; counter=0.
//  FSM IDLE -> SETTLE -> RESP -> IDLE.
//  IDLE: req_ready=1. On req_valid&&req_ready edge: register req_* onto tile_*,
//   load counter=SETTLE_CYCLES, go SETTLE. req_ready=0 in SETTLE and RESP.
//  SETTLE: each edge with counter!=0 decrements. Edge with counter==0: capture
//   rsp_result=OR of tile_result slices, rsp_tile=lowest i with tile_match[i] (else 4'hF),
//   rsp_err=(popcount(tile_match)!=1), rsp_mode=tile_mode; rsp_valid=1; go RESP.
//  Latency: rsp_valid rises SETTLE_CYCLES+1 edges after the accept edge.
//  RESP: all rsp_* held stable while rsp_valid&&!rsp_ready. On rsp_valid&&rsp_ready edge:
//   rsp_valid=0, op_count+=1, tile_mode=IDLE_MODE, tile_a/b hold, go IDLE (req_ready=1 next cycle).
//  No same-cycle response+accept: min op interval is SETTLE_CYCLES+3 cycles.
//  req_mode>8 is dispatched unchanged; no match -> rsp_err=1, rsp_result=0, rsp_tile=4'hF.
//  Multi-match: rsp_err=1, rsp_tile=lowest index, rsp_result=OR of all slices.
//  Changes on req_* while req_ready=0 are ignored; tile_* change only on accept/response.
//  Reset mid-op: op discarded, all outputs to reset values immediately, no response.
//  tile_match/tile_result are only sampled on the capture edge.
// TESTING
//  T1 a=5,b=7,mode=0, rsp_ready=1 -> rsp_valid 2 edges after accept; result=12, tile=0, err=0.
//  T2 a=100,b=0,mode=3 then a=100,b=7,mode=3 -> results 0 then 14, tile=3, err=0, op_count=2.
//  T3 mode=9, a=1,b=1 -> rsp_result=0, rsp_tile=4'hF, rsp_err=1; mesh sees tile_mode=9 then IDLE_MODE.
//  T4 a=1,b=63,mode=7, rsp_ready low 5 cycles -> rsp_* stable 0x8000_0000_0000_0000,
//   req_ready=0, new req_valid ignored; release -> single response, op_count+1.
//  T5 stub mesh drives tile_match=9'b000010100, results 0xF0 and 0x0F -> result 0xFF, tile=2, err=1.
//  T6 rst_n low during SETTLE -> immediate reset values, no rsp_valid; next op behaves as T1.

Source files
------------

// File: rtl/alu_mesh_dispatch.sv
// Request front-end for the ALU tile mesh: broadcasts one op,
// waits a settle window, then gathers tile results into one response.
module alu_mesh_dispatch #(
  parameter int          NUM_TILES     = 9,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [3:0]  IDLE_MODE     = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_a,
  input  logic [63:0]             req_b,
  input  logic [3:0]              req_mode,
  output logic [63:0]             tile_a,
  output logic [63:0]             tile_b,
  output logic [3:0]              tile_mode,
  input  logic [64*NUM_TILES-1:0] tile_result,
  input  logic [NUM_TILES-1:0]    tile_match,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [63:0]             rsp_result,
  output logic [3:0]              rsp_mode,
  output logic [3:0]              rsp_tile,
  output logic                    rsp_err,
  output logic [31:0]             op_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic [63:0] tile_a_q;
  logic [63:0] tile_b_q;
  logic [3:0]  tile_mode_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_result_q;
  logic [3:0]  rsp_mode_q;
  logic [3:0]  rsp_tile_q;
  logic        rsp_err_q;
  logic [31:0] op_count_q;

  logic [63:0] res_d;
  logic [3:0]  tile_d;
  logic        found_d;
  logic [4:0]  hits_d;
  logic        err_d;

  // Gather the mesh: OR of all slices, lowest matching tile, hit count.
  always_comb begin
    res_d   = '0;
    tile_d  = 4'hF;
    found_d = 1'b0;
    hits_d  = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      res_d = res_d | tile_result[64*i +: 64];
      if (tile_match[i]) begin
        hits_d = hits_d + 5'd1;
        if (!found_d) begin
          tile_d  = 4'(i);
          found_d = 1'b1;
        end
      end
    end
    err_d = (hits_d != 5'd1);
  end

  // Dispatch FSM: accept, settle, hold the response until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      tile_a_q     <= '0;
      tile_b_q     <= '0;
      tile_mode_q  <= IDLE_MODE;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_mode_q   <= '0;
      rsp_tile_q   <= 4'hF;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            tile_a_q    <= req_a;
            tile_b_q    <= req_b;
            tile_mode_q <= req_mode;
            cnt_q       <= SETTLE_LD;
            req_ready_q <= 1'b0;
            state_q     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_result_q <= res_d;
            rsp_tile_q   <= tile_d;
            rsp_err_q    <= err_d;
            rsp_mode_q   <= tile_mode_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 32'd1;
            tile_mode_q <= IDLE_MODE;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign tile_a     = tile_a_q;
  assign tile_b     = tile_b_q;
  assign tile_mode  = tile_mode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_mode   = rsp_mode_q;
  assign rsp_tile   = rsp_tile_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_mesh_dispatch.sv
// Bench for alu_mesh_dispatch: stub tile mesh plus a
// transaction-level reference for each response.
module tb_alu_mesh_dispatch;

  localparam int NT = 9;
  localparam int SC = 1;
  localparam logic [3:0] IDLE = 4'hF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [63:0]     req_a = '0;
  logic [63:0]     req_b = '0;
  logic [3:0]      req_mode = '0;
  logic [63:0]     tile_a;
  logic [63:0]     tile_b;
  logic [3:0]      tile_mode;
  logic [64*NT-1:0] tile_result;
  logic [NT-1:0]   tile_match;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [63:0]     rsp_result;
  logic [3:0]      rsp_mode;
  logic [3:0]      rsp_tile;
  logic            rsp_err;
  logic [31:0]     op_count;

  int tests = 0;
  int failed = 0;
  logic [31:0] exp_cnt = '0;

  logic             ovr = 1'b0;
  logic [NT-1:0]    ovr_match = '0;
  logic [64*NT-1:0] ovr_res = '0;

  alu_mesh_dispatch #(
    .NUM_TILES(NT), .SETTLE_CYCLES(SC), .IDLE_MODE(IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
    .tile_a(tile_a), .tile_b(tile_b), .tile_mode(tile_mode),
    .tile_result(tile_result), .tile_match(tile_match),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_mode(rsp_mode),
    .rsp_tile(rsp_tile), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Tile i implements op i.
  function automatic logic [63:0] tile_op(
    int m, logic [63:0] a, logic [63:0] b);
    case (m)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return (b == 0) ? 64'd0 : a / b;
      4: return a | b;
      5: return a ^ b;
      6: return a >> b[5:0];
      7: return a << b[5:0];
      8: return a * b;
      default: return 64'd0;
    endcase
  endfunction

  // Stub mesh: behavioural tiles, or a forced pattern.
  always_comb begin
    tile_result = '0;
    tile_match  = '0;
    if (ovr) begin
      tile_result = ovr_res;
      tile_match  = ovr_match;
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (tile_mode == 4'(i)) begin
          tile_match[i] = 1'b1;
          tile_result[64*i +: 64] = tile_op(i, tile_a, tile_b);
        end
      end
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(
    string tag, logic [63:0] a, logic [63:0] b, logic [3:0] m,
    int hold, logic [63:0] e_res, logic [3:0] e_tile, logic e_err);
    int n;
    @(negedge clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_mode = m;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({tag, ".tmode"}, 64'(tile_mode), 64'(m));
    chk({tag, ".ta"}, tile_a, a);
    chk({tag, ".busy"}, 64'(req_ready), 64'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rsp_valid && n < 40);
    chk({tag, ".lat"}, 64'(n), 64'(SC + 1));
    chk({tag, ".res"}, rsp_result, e_res);
    chk({tag, ".tile"}, 64'(rsp_tile), 64'(e_tile));
    chk({tag, ".err"}, 64'(rsp_err), 64'(e_err));
    chk({tag, ".mode"}, 64'(rsp_mode), 64'(m));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_a = 64'(h + 77);
      req_mode = 4'(h);
      @(posedge clk);
      #1;
      chk({tag, ".hv"}, 64'(rsp_valid), 64'd1);
      chk({tag, ".hres"}, rsp_result, e_res);
      chk({tag, ".hta"}, tile_a, a);
      chk({tag, ".hrdy"}, 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk({tag, ".done"}, 64'(rsp_valid), 64'd0);
    chk({tag, ".cnt"}, 64'(op_count), 64'(exp_cnt));
    chk({tag, ".idle"}, 64'(tile_mode), 64'(IDLE));
    chk({tag, ".tb"}, tile_b, b);
  endtask

  task automatic run_std(
    string tag, logic [63:0] a, logic [63:0] b, logic [3:0] m, int hold);
    if (m <= 4'd8)
      run_op(tag, a, b, m, hold, tile_op(int'(m), a, b), m, 1'b0);
    else
      run_op(tag, a, b, m, hold, 64'd0, 4'hF, 1'b1);
  endtask

  initial begin
    logic [63:0] e_res;
    logic [3:0]  e_tile;
    int          idx;
    #12;
    chk("rst.ready", 64'(req_ready), 64'd1);
    chk("rst.tmode", 64'(tile_mode), 64'(IDLE));
    chk("rst.ta", tile_a, 64'd0);
    chk("rst.rv", 64'(rsp_valid), 64'd0);
    chk("rst.tile", 64'(rsp_tile), 64'hF);
    chk("rst.cnt", 64'(op_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("T1", 64'd5, 64'd7, 4'd0, 0, 64'd12, 4'd0, 1'b0);
    run_op("T2a", 64'd100, 64'd0, 4'd3, 0, 64'd0, 4'd3, 1'b0);
    run_op("T2b", 64'd100, 64'd7, 4'd3, 0, 64'd14, 4'd3, 1'b0);
    run_op("T3", 64'd1, 64'd1, 4'd9, 0, 64'd0, 4'hF, 1'b1);
    run_op("T4", 64'd1, 64'd63, 4'd7, 5,
           64'h8000_0000_0000_0000, 4'd7, 1'b0);

    ovr = 1'b1;
    ovr_match = 9'b000010100;
    ovr_res = '0;
    ovr_res[64*2 +: 64] = 64'hF0;
    ovr_res[64*4 +: 64] = 64'h0F;
    run_op("T5", 64'd3, 64'd4, 4'd2, 1, 64'hFF, 4'd2, 1'b1);

    for (int k = 0; k < 12; k++) begin
      ovr_match = NT'($urandom);
      if (k % 3 == 0) ovr_match = NT'(1) << $urandom_range(NT - 1);
      if (k == 5) ovr_match = '0;
      e_res = '0;
      e_tile = 4'hF;
      idx = -1;
      for (int t = NT - 1; t >= 0; t--) begin
        ovr_res[64*t +: 64] = {$urandom, $urandom};
        e_res = e_res | ovr_res[64*t +: 64];
        if (ovr_match[t]) idx = t;
      end
      if (idx >= 0) e_tile = 4'(idx);
      run_op("RM", {$urandom, $urandom}, 64'd1,
             4'($urandom_range(8)), $urandom_range(2),
             e_res, e_tile, ($countones(ovr_match) != 1));
    end
    ovr = 1'b0;

    for (int k = 0; k < 16; k++) begin
      run_std("RS", {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom_range(11)), $urandom_range(2));
    end

    @(negedge clk);
    req_valid = 1'b1;
    req_a = 64'd5;
    req_b = 64'd7;
    req_mode = 4'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    chk("T6.rv", 64'(rsp_valid), 64'd0);
    chk("T6.ready", 64'(req_ready), 64'd1);
    chk("T6.tmode", 64'(tile_mode), 64'(IDLE));
    chk("T6.ta", tile_a, 64'd0);
    chk("T6.cnt", 64'(op_count), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("T6.norsp", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("T6b", 64'd5, 64'd7, 4'd0, 0, 64'd12, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
